// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI slave sequence checker.
package spi_pkg;

    localparam int WORD_BITS_DEF = 16;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous bus line, with rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_65,
    input  logic RST,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_sr;
    logic                   q_prev;

    always_ff @(posedge CLK_65) begin
        if (RST) begin
            sync_sr <= '0;
            q_prev  <= 1'b0;
        end else begin
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], d};
            q_prev  <= sync_sr[SYNC_STAGES-1];
        end
    end

    assign q    = sync_sr[SYNC_STAGES-1];
    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;

endmodule

// File: rtl/spi_slave_seq_checker.sv
// SPI mode-0 slave receiver that checks received words form an incrementing
// counter, keeps word/error statistics and echoes the last word on MISO.
//
// state     | meaning
// WAIT_IDLE | bus ignored until CSbar seen high (no partial-frame capture)
// IDLE      | waiting for CSbar fall
// SHIFT     | shifting bits; completes words, bursts allowed
module spi_slave_seq_checker
    import spi_pkg::*;
#(
    parameter int WORD_BITS   = WORD_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK_65,
    input  logic                 RST,
    input  logic                 ENA,
    input  logic                 SCK,
    input  logic                 MOSI,
    input  logic                 CSbar,
    output logic                 MISO,
    output logic                 MISO_OE,
    output logic [WORD_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 SEQ_ERR,
    output logic                 FRAME_ERR,
    output logic [CNT_W-1:0]     WORD_COUNT,
    output logic [CNT_W-1:0]     ERR_COUNT,
    output logic                 BUSY
);

    localparam int BC_W = $clog2(WORD_BITS + 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(WORD_BITS);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_BITS - 1);

    logic sck_q, sck_rise, sck_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .CLK_65(CLK_65), .RST(RST), .d(SCK),
        .q(sck_q), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .CLK_65(CLK_65), .RST(RST), .d(CSbar),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .CLK_65(CLK_65), .RST(RST), .d(MOSI),
        .q(mosi_q), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t                 state;
    logic [BC_W-1:0]        bit_cnt;
    logic [WORD_BITS-1:0]   rx_sr;
    logic [WORD_BITS-1:0]   miso_sr;
    logic [WORD_BITS-1:0]   expected;
    logic                   seeded;

    always_ff @(posedge CLK_65) begin
        RX_VALID  <= 1'b0;
        SEQ_ERR   <= 1'b0;
        FRAME_ERR <= 1'b0;
        if (RST) begin
            state      <= WAIT_IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            miso_sr    <= '0;
            expected   <= '0;
            seeded     <= 1'b0;
            MISO       <= 1'b0;
            MISO_OE    <= 1'b0;
            RX_DATA    <= '0;
            WORD_COUNT <= '0;
            ERR_COUNT  <= '0;
        end else begin
            MISO_OE <= ENA & ~cs_q;
            if (!ENA) begin
                state   <= WAIT_IDLE;
                bit_cnt <= '0;
                seeded  <= 1'b0;
            end else begin
                case (state)
                    WAIT_IDLE: begin
                        bit_cnt <= '0;
                        if (cs_q) state <= IDLE;
                    end
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                            miso_sr <= RX_DATA;
                            MISO    <= RX_DATA[WORD_BITS-1];
                        end
                    end
                    SHIFT: begin
                        if (bit_cnt == BC_FULL) begin
                            RX_DATA    <= rx_sr;
                            RX_VALID   <= 1'b1;
                            WORD_COUNT <= WORD_COUNT + 1'b1;
                            bit_cnt    <= '0;
                            miso_sr    <= rx_sr;
                            MISO       <= rx_sr[WORD_BITS-1];
                            expected   <= rx_sr + 1'b1;
                            seeded     <= 1'b1;
                            if (seeded && rx_sr != expected) begin
                                SEQ_ERR <= 1'b1;
                                if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + 1'b1;
                            end
                            // CSbar may have risen with or just after the last bit
                            if (cs_q) state <= IDLE;
                        end else begin
                            if (sck_rise) begin
                                rx_sr   <= {rx_sr[WORD_BITS-2:0], mosi_q};
                                bit_cnt <= bit_cnt + 1'b1;
                            end else if (sck_fall && bit_cnt != '0) begin
                                // the fall after a word's last bit keeps the reloaded MSB
                                miso_sr <= miso_sr << 1;
                                MISO    <= miso_sr[WORD_BITS-2];
                            end
                            if (cs_rise && !(sck_rise && bit_cnt == BC_LAST)) begin
                                state   <= IDLE;
                                bit_cnt <= '0;
                                if (bit_cnt != '0) FRAME_ERR <= 1'b1;
                            end
                        end
                    end
                    default: state <= WAIT_IDLE;
                endcase
            end
        end
    end

    assign BUSY = (state == SHIFT);

endmodule

// File: doc/spi_slave_seq_checker.md
Name: spi_slave_seq_checker

Overview:
SPI slave receiver and stream checker on CLK_65. It accepts 16-bit words shifted in by an external SPI master (MBED or a second board running the counter/FIFO/SPI-master path). It verifies that successive words form an incrementing counter sequence and reports word, error and framing statistics. It also echoes the last received word on MISO so the master can read back what arrived.

Parameters:
WORD_BITS, 16, bits per SPI word, MSB first
SYNC_STAGES, 2, flip-flop stages in the SCK/MOSI/CSbar input synchronisers (minimum 2)

Ports:
CLK_65  in  1  system clock, 65 MHz
RST  in  1  reset, synchronous, active-high
ENA  in  1  receive/check enable; low = ignore bus
SCK  in  1  SPI clock from master, asynchronous
MOSI  in  1  SPI data from master, asynchronous
CSbar  in  1  SPI chip select from master, active-low, asynchronous
MISO  out  1  SPI data to master
MISO_OE  out  1  high while CSbar (synced) low and ENA high; top level tristates MISO otherwise
RX_DATA  out  WORD_BITS  last complete word received
RX_VALID  out  1  one-cycle pulse when RX_DATA updates
SEQ_ERR  out  1  one-cycle pulse coincident with RX_VALID when word != expected
FRAME_ERR  out  1  one-cycle pulse on CSbar rise with partial word
WORD_COUNT  out  16  valid words received, wraps at 0xFFFF->0
ERR_COUNT  out  16  sequence errors, saturates at 0xFFFF
BUSY  out  1  high in SHIFT state

Behaviour:
- Reset: all outputs 0, RX_DATA 0, counters 0, MISO 0, checker unseeded, FSM -> WAIT_IDLE.
- Inputs pass through SYNC_STAGES FFs; edges are detected on the synchronised SCK and CSbar (prev vs current).
- Bus requirement: SCK half-period >= 4 CLK_65 cycles; mode 0 (CPOL=0, CPHA=0).
- FSM WAIT_IDLE: wait for synced CSbar high -> IDLE. This guarantees reset or ENA rise mid-frame never captures a partial frame.
- FSM IDLE: on CSbar fall with ENA=1 -> SHIFT. Clear bit counter; load MISO shift register with RX_DATA; drive its MSB on MISO.
- FSM SHIFT, SCK rise: shift synced MOSI into rx shift register LSB, bit_cnt+1.
- FSM SHIFT, SCK fall: shift MISO register left; next bit appears on MISO.
- When bit_cnt reaches WORD_BITS on a rise, on the next cycle:
  - RX_DATA <= shift register.
  - RX_VALID=1; WORD_COUNT+1.
  - bit_cnt <- 0 and FSM stays in SHIFT (multi-word bursts within one CSbar low are legal).
  - MISO register reloads with the new word.
- FSM SHIFT, CSbar rise:
  - bit_cnt==0: -> IDLE, no pulse.
  - 1..WORD_BITS-1: FRAME_ERR pulse, partial word discarded, -> IDLE.
- Simultaneous last-bit SCK rise and CSbar rise in the same cycle: complete the word (RX_VALID), no FRAME_ERR.
- ENA low: FSM -> WAIT_IDLE; counters and RX_DATA held; MISO_OE=0; checker unseeded.
- Checker, first valid word after reset or ENA rise: seed only, expected <= word+1, no SEQ_ERR.
- Checker, later words:
  - Compare to expected (mod 2^16; 0xFFFF followed by 0x0000 is correct).
  - On mismatch: SEQ_ERR with RX_VALID; ERR_COUNT+1, saturating.
  - Always re-seed: expected <= word+1, so one dropped word costs exactly one error.
- RST mid-frame: immediate clear per reset rule; remaining SCK edges of that frame are ignored (WAIT_IDLE).

Decomposition:
- Shared package spi_pkg:
  - WORD_BITS default.
  - FSM state encoding localparams WAIT_IDLE/IDLE/SHIFT.
  - Counter width constant (16).
- One sub-module, spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instanced for SCK and CSbar; MOSI uses the data output only.

Test Plan:
- Reset, then CSbar low, 16 SCK (8-cycle half period) shifting 0x1234, CSbar high -> RX_DATA=0x1234, one RX_VALID, WORD_COUNT=1, SEQ_ERR=0.
- Frames 0xFFFE, 0xFFFF, 0x0000, 0x0001 -> 4 RX_VALID, ERR_COUNT=0, WORD_COUNT=4.
- Frames 5, 6, 8, 9 -> single SEQ_ERR on word 8, ERR_COUNT=1.
- CSbar high after 9 bits -> FRAME_ERR pulse, RX_DATA unchanged, WORD_COUNT unchanged. Next full frame 0x00AA is received correctly.
- One CSbar-low burst of 32 SCK with 0xA5A5, 0xA5A6 -> two RX_VALID pulses. MISO bits during word 2 equal 0xA5A5 MSB first.
- RST pulse after bit 7 with CSbar still low; master finishes the frame, then sends 0x0042 -> no RX_VALID for the aborted frame; RX_DATA=0x0042, WORD_COUNT=1, seed only.
